// File: rtl/mem_stage_sram.sv
// Memory stage: turns each 32-bit load/store into two 16-bit accesses on an async SRAM.
// Latency: 2*ACCESS_CYCLES+2 cycles per memory op (request cycle, LO, HI, DONE); zero for non-memory ops.
// Backpressure: ready is low from the request cycle until DONE, stalling every pipeline register.
// Ports: clk/rst, MEM_R_EN/MEM_W_EN/ALU_result/Val_Rm from EXE/MEM, MEM_result/ready to the pipeline,
//        SRAM_ADDR/SRAM_DQ/SRAM_WE_N/SRAM_OE_N to the external SRAM.
module mem_stage_sram #(
  parameter int ACCESS_CYCLES = 2,
  parameter int BASE_ADDR     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_Rm,
  output logic [31:0] MEM_result,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic        req;
  logic        active;
  logic        last;
  logic        half;
  logic [31:0] widx;
  logic        dq_oe;
  logic [15:0] dq_out;
  logic        unused_widx;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign active = (state == LO) || (state == HI);
  assign last   = active && (cnt == LAST_CNT);
  assign half   = (state == HI);

  // Address is re-derived every cycle; upstream holds ALU_result stable while stalled.
  // Out-of-range addresses simply wrap through the truncation to 17 bits.
  assign widx        = (ALU_result - BASE) >> 2;
  assign SRAM_ADDR   = {widx[16:0], half};
  assign unused_widx = ^widx[31:17];

  assign SRAM_DQ = dq_oe ? dq_out : 'z;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Phase counter, latched op type and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      op_wr      <= 1'b0;
      MEM_result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          // Store wins when both enables are set.
          if (req) op_wr <= MEM_W_EN;
        end
        LO, HI: begin
          cnt <= last ? 4'd0 : cnt + 4'd1;
          // Read data is sampled at the end of each phase, after the full access time.
          if (last && !op_wr) begin
            if (state == LO) MEM_result[15:0]  <= SRAM_DQ;
            else             MEM_result[31:16] <= SRAM_DQ;
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = LO;
      LO:      if (last) next_state = HI;
      HI:      if (last) next_state = DONE;
      // The request is still visible in DONE but must not start a second access.
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = Val_Rm[15:0];
    case (state)
      IDLE: ready = !req;
      DONE: ready = 1'b1;
      LO, HI: begin
        if (op_wr) begin
          dq_oe  = 1'b1;
          dq_out = half ? Val_Rm[31:16] : Val_Rm[15:0];
          // WE_N rises on the last cycle so address/data stay valid past the write edge.
          SRAM_WE_N = last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_result;
  logic [31:0] Val_Rm;
  logic [31:0] MEM_result;
  logic        ready;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;

  int n_assert = 0;
  int n_fail   = 0;

  // Small SRAM model: 64 half-words, indexed by the low address bits.
  logic [15:0] sram [0:63] = '{default: 16'hAAAA};
  logic        sram_drive;

  assign sram_drive = !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ    = sram_drive ? sram[SRAM_ADDR[5:0]] : 'z;

  always @(posedge clk) begin
    if (!SRAM_WE_N) sram[SRAM_ADDR[5:0]] <= SRAM_DQ;
  end

  mem_stage_sram #(.ACCESS_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_result (ALU_result),
    .Val_Rm     (Val_Rm),
    .MEM_result (MEM_result),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Presents one instruction (entered just after a rising edge), samples at each falling
  // edge until ready, then lets the pipeline advance past DONE and returns to idle inputs.
  // Patterns shift in WE_N/OE_N on every stalled cycle; res is MEM_result seen in DONE.
  task automatic do_op(input logic r, input logic w, input logic [31:0] addr,
                       input logic [31:0] val, output int low, output logic [7:0] we_pat,
                       output logic [7:0] oe_pat, output logic [31:0] res);
    bit done;
    MEM_R_EN   = r;
    MEM_W_EN   = w;
    ALU_result = addr;
    Val_Rm     = val;
    low    = 0;
    we_pat = 8'h00;
    oe_pat = 8'h00;
    res    = 32'hX;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready) begin
        res  = MEM_result;
        done = 1'b1;
      end else begin
        low++;
        we_pat = {we_pat[6:0], SRAM_WE_N};
        oe_pat = {oe_pat[6:0], SRAM_OE_N};
      end
    end
    chk("op_completes", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  int          low;
  logic [7:0]  we_pat;
  logic [7:0]  oe_pat;
  logic [31:0] res;

  initial begin
    rst        = 1'b1;
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    ALU_result = 32'd0;
    Val_Rm     = 32'd0;

    // Reset state; address 0 is below BASE_ADDR and wraps to word 0x1FF00.
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
    chk("rst_result", MEM_result, 32'd0);
    chk("wrap_addr", {14'd0, SRAM_ADDR}, 32'h3FE00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Start a write, then assert reset while in LO.
    MEM_W_EN   = 1'b1;
    ALU_result = 32'd1024;
    Val_Rm     = 32'hCAFEF00D;
    @(negedge clk);
    chk("req_cycle_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("lo_we_n", {31'd0, SRAM_WE_N}, 32'd0);
    chk("lo_addr", {14'd0, SRAM_ADDR}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("midrst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
    chk("midrst_result", MEM_result, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    #1 rst = 1'b0;
    // Held request restarts from LO; this cycle is its request cycle, so 4 more stalled cycles.
    do_op(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, low, we_pat, oe_pat, res);
    chk("restart_low", low, 32'd4);
    chk("restart_we", {24'd0, we_pat}, 32'h05);
    chk("restart_hw0", {16'd0, sram[0]}, 32'hF00D);
    chk("restart_hw1", {16'd0, sram[1]}, 32'hCAFE);

    // Store 0xDEADBEEF at 1024.
    do_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, low, we_pat, oe_pat, res);
    chk("st0_low", low, 32'd5);
    chk("st0_we", {24'd0, we_pat}, 32'h15);
    chk("st0_oe", {24'd0, oe_pat}, 32'h1F);
    chk("st0_hw0", {16'd0, sram[0]}, 32'hBEEF);
    chk("st0_hw1", {16'd0, sram[1]}, 32'hDEAD);
    chk("st0_result", res, 32'd0);

    // Load it back.
    do_op(1'b1, 1'b0, 32'd1024, 32'h0, low, we_pat, oe_pat, res);
    chk("ld0_low", low, 32'd5);
    chk("ld0_we", {24'd0, we_pat}, 32'h1F);
    chk("ld0_oe", {24'd0, oe_pat}, 32'h10);
    chk("ld0_result", res, 32'hDEADBEEF);

    // Store then load at 1028, back to back.
    do_op(1'b0, 1'b1, 32'd1028, 32'h12345678, low, we_pat, oe_pat, res);
    chk("st1_low", low, 32'd5);
    chk("st1_hw2", {16'd0, sram[2]}, 32'h5678);
    chk("st1_hw3", {16'd0, sram[3]}, 32'h1234);
    chk("st1_result", res, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 32'd1028, 32'h0, low, we_pat, oe_pat, res);
    chk("ld1_low", low, 32'd5);
    chk("ld1_result", res, 32'h12345678);

    // Non-memory instruction: no stall, idle pins, result held, address still tracked.
    ALU_result = 32'd2000;
    Val_Rm     = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alu_ready", {31'd0, ready}, 32'd1);
      chk("alu_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      chk("alu_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
      chk("alu_result", MEM_result, 32'h12345678);
    end
    chk("alu_addr", {14'd0, SRAM_ADDR}, 32'd488);
    @(posedge clk);
    #1;

    // Both enables set: behaves as a store.
    do_op(1'b1, 1'b1, 32'd1032, 32'h0000FFFF, low, we_pat, oe_pat, res);
    chk("both_low", low, 32'd5);
    chk("both_we", {24'd0, we_pat}, 32'h15);
    chk("both_oe", {24'd0, oe_pat}, 32'h1F);
    chk("both_hw4", {16'd0, sram[4]}, 32'hFFFF);
    chk("both_hw5", {16'd0, sram[5]}, 32'h0000);
    chk("both_result", res, 32'h12345678);

    @(negedge clk);
    chk("final_ready", {31'd0, ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the five-stage ARM pipeline. It sits directly downstream of the execute stage's pipeline register and consumes its ALU result (the effective byte address) and forwarded store value. Each 32-bit load or store becomes two 16-bit accesses on an external asynchronous SRAM. While an access is in flight, `ready` is deasserted so the hazard/freeze logic stalls every pipeline register.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: clock cycles spent on each 16-bit half access; legal range 2–15.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `MEM_R_EN`  in  1  load request from the EXE/MEM register.
- `MEM_W_EN`  in  1  store request from the EXE/MEM register.
- `ALU_result`  in  32  effective byte address.
- `Val_Rm`  in  32  store data, already forwarded.
- `MEM_result`  out  32  loaded word, registered.
- `ready`  out  1  high when the stage is not stalling the pipeline.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_WE_N`  out  1  active-low write enable.
- `SRAM_OE_N`  out  1  active-low output enable.

## Operation
- Word index `widx = (ALU_result - BASE_ADDR) >> 2`, computed in 32 bits.
- `SRAM_ADDR = {widx[16:0], half}`, where `half` = 0 for the low halfword and 1 for the high halfword.
- Addresses are not range-checked. An address below `BASE_ADDR` or beyond 128K words wraps through the truncation.
- State machine states: IDLE, LO, HI, DONE. A 4-bit counter `cnt` tracks cycles within LO and HI.
  - IDLE: if `MEM_R_EN | MEM_W_EN`, latch the operation type (write if `MEM_W_EN`, which wins when both are asserted), set `cnt` = 0, and go to LO. Otherwise stay in IDLE.
  - LO: `half` = 0. `cnt` increments each cycle. When `cnt == ACCESS_CYCLES-1`, reset `cnt` to 0 and go to HI.
  - HI: `half` = 1. Same counting rule as LO. On the last cycle, go to DONE.
  - DONE: single cycle, then go to IDLE unconditionally. The request still visible in this cycle is never re-accepted.
- `ready` is combinational:
  - In IDLE: `ready = !(MEM_R_EN | MEM_W_EN)`.
  - In DONE: `ready = 1`.
  - In LO and HI: `ready = 0`.
- Upstream holds `ALU_result`, `Val_Rm` and the enables stable while `ready` = 0. The block re-derives the address from its inputs each cycle and keeps no internal address copy.
- Read:
  - `SRAM_OE_N` = 0 throughout LO and HI.
  - `SRAM_DQ` is high-Z.
  - On the last cycle of LO, capture `SRAM_DQ` into `MEM_result[15:0]`. On the last cycle of HI, capture it into `MEM_result[31:16]`.
- Write:
  - `SRAM_DQ` drives `Val_Rm[15:0]` during LO and `Val_Rm[31:16]` during HI.
  - `SRAM_WE_N` = 0 on every LO/HI cycle except the last cycle of each phase, so data and address are held while WE_N is high.
  - `SRAM_OE_N` = 1.
  - `MEM_result` is unchanged.
- Outside LO/HI:
  - `SRAM_DQ` is high-Z and `SRAM_WE_N` = `SRAM_OE_N` = 1.
  - `SRAM_ADDR` still tracks `widx` with `half` = 0.

## Timing
- Reset values: state IDLE, `cnt` 0, `MEM_result` 0, `SRAM_WE_N` 1, `SRAM_OE_N` 1, `SRAM_DQ` high-Z. `ready` then follows its combinational rule.
- Request first seen in IDLE at cycle 0. LO occupies cycles 1..AC, HI occupies AC+1..2AC, and DONE is cycle 2AC+1, where AC = `ACCESS_CYCLES`.
- With AC = 2, `ready` is low for cycles 0–4 and high in cycle 5, so the pipeline advances at the end of cycle 5.
- `MEM_result` is valid from DONE onward and holds until the next read completes its LO capture.
- Non-memory instruction: zero stall; `ready` = 1 in the same cycle.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after DONE. There is no overlap between ops.
- Reset asserted mid-access: the block immediately returns to reset values, and a partially written word is left as-is in SRAM. After reset deasserts, a still-asserted request starts from LO.

## Test plan
- Reset: assert `rst` during LO of a write → `SRAM_WE_N` = 1, `SRAM_DQ` = Z, `MEM_result` = 0 on the same cycle. After release, the held request restarts and `ready` goes high 5 cycles later.
- Store `0xDEADBEEF` at address 1024, AC = 2 → SRAM model holds half-word 0 = `0xBEEF` and half-word 1 = `0xDEAD`. `ready` is low for exactly 5 cycles. `SRAM_WE_N` pattern over LO,LO,HI,HI is 0,1,0,1.
- Load from 1024 after that store → `MEM_result` = `0xDEADBEEF` in DONE. `SRAM_OE_N` is low for 4 cycles and `SRAM_DQ` is never driven by the DUT.
- Store `0x12345678` to 1028, then load from 1028 on the next accepted instruction → SRAM half-words 2/3 = `0x5678`/`0x1234`. Load returns `0x12345678` with no re-accept in DONE.
- ALU instruction with both enables low → `ready` = 1 every cycle, SRAM pins idle, `MEM_result` unchanged.
- `MEM_R_EN` = `MEM_W_EN` = 1 with `Val_Rm` = `0x0000FFFF` at 1032 → treated as a write: half-words 4/5 = `0xFFFF`/`0x0000`, and `MEM_result` unchanged.
